minplus_reduce_ctrl: RTL and testbench
======================================

Name: minplus_reduce_ctrl

Overview:
- Sequencing controller for the min-reduction datapath used by the min-plus (tropical semiring) extended tensor core.
- Computes out = min(c_seed, min over k of sat(a_k + b_k)) for one dot-product row.
- The row is streamed in as `len` beats of LANES element pairs. Each beat passes through a lane adder plus a combinational min tree, and the result is folded into a registered accumulator.
- Sits between the operand fetch/staging logic and the result writeback, with valid/ready handshakes on both sides.

Parameters:
- W, 16, element width; unsigned; all-ones = +infinity.
- LANES, 4, element pairs per input beat; power of two, 1..16.
- LEN_W, 8, width of the beat-count field.

Ports:
- clk, input, 1, single clock; all state updates on the rising edge.
- rst, input, 1, synchronous active-high reset.
- start, input, 1, request a new reduction; accepted only in IDLE.
- len, input, LEN_W, number of beats in the row; sampled on start acceptance.
- c_seed, input, W, initial accumulator value; sampled on start acceptance.
- busy, output, 1, high whenever state != IDLE.
- in_valid, input, 1, operand beat valid.
- in_ready, output, 1, controller can accept a beat.
- a_in, input, LANES*W, lane i occupies bits [i*W +: W].
- b_in, input, LANES*W, same packing as a_in.
- out_valid, output, 1, result valid.
- out_ready, input, 1, downstream accepts the result.
- out, output, W, reduction result.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE; acc=0; beat counter=0.
  - busy=0, in_ready=0, out_valid=0, out=0.
  - rst asserted mid-operation discards the row and any pending result; no partial output is produced.
- States: IDLE, ACCUM, DONE.
- IDLE:
  - in_ready=0, out_valid=0.
  - start=1: capture len and c_seed, set acc=c_seed, clear the counter.
  - Next state is ACCUM if len!=0, else DONE.
- ACCUM:
  - in_ready=1 (registered, combinationally equal to state==ACCUM).
  - A beat is accepted when in_valid & in_ready.
  - Lane sum s_i = a_i + b_i, computed W+1 bits wide; if the carry is set, s_i = all-ones (saturate to infinity).
  - beat_min = unsigned min over all s_i, using a balanced pairwise tree; on a tie the lower lane index wins.
  - acc <= (acc <= beat_min) ? acc : beat_min.
  - The counter increments on each accepted beat. The beat accepted when counter == len-1 moves the state to DONE.
  - Cycles with in_valid=0 change nothing; there is no timeout.
- DONE:
  - out_valid=1 and out=acc, held stable until out_ready=1.
  - On the out_ready handshake, next state is IDLE, out_valid drops the following cycle, and out retains its last value.
- Latency:
  - out_valid rises the cycle after the final beat is accepted.
  - For len=0, out_valid rises the cycle after start.
  - Minimum cycles from start to the result handshake = len+1.
- Throughput: one beat per cycle in ACCUM; at most one row in flight.
- start while busy=1 is ignored; it is not queued.
  - start asserted in DONE in the same cycle as out_ready is ignored.
  - The earliest next start is accepted the cycle after returning to IDLE.
- Arithmetic is unsigned throughout. Comparison is <=, so equal values keep the accumulator.
- Operands equal to all-ones act as infinity and propagate correctly through saturation.
- No combinational path from in_valid or out_ready to in_ready or out_valid.

Test Plan:
1. len=1, c_seed=100, a={1,2,3,4}, b={10,5,50,0} (lanes 0..3): sums 11,7,53,4 → out_valid the cycle after the beat, out=4; in_ready=0 before start and after the beat.
2. len=3, c_seed=100, beats with minima 20, 9, 15, with in_valid gaps of 2 cycles between beats → out=9, exactly 3 beats consumed, out_valid the cycle after the third beat.
3. Saturation: len=1, all lanes a=0xFFF0, b=0x0020 → sums clamp to 0xFFFF. With c_seed=0xFFFF → out=0xFFFF; with c_seed=5 → out=5.
4. len=0, c_seed=42 → out_valid=1 the next cycle with out=42; in_ready never asserted.
5. Backpressure: in DONE, hold out_ready=0 for 5 cycles while pulsing start → out stays stable, start is ignored, busy=1. Release out_ready → IDLE next cycle, and a new start is then accepted.
6. Reset mid-row: len=4, rst asserted after 2 beats → busy=0, in_ready=0, out_valid=0 on the next cycle. A fresh start with len=1 then produces the correct result, unaffected by the discarded partial row.

Source files
------------

// File: rtl/minplus_reduce_ctrl.sv
// minplus_reduce_ctrl
//   Min-reduction sequencer for the min-plus tensor core. Folds a streamed
//   row of `len` beats into out = min(c_seed, min_k sat(a_k + b_k)).
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   start/len/c_seed: row request (accepted only when idle)
//   busy            : controller is not idle
//   in_valid/in_ready, a_in/b_in : operand beats, LANES lanes of W bits each
//                     (lane i in bits [i*W +: W])
//   out_valid/out_ready, out     : result handshake
//
// Sub-modules
//   minplus_lane    : one saturating lane adder (all-ones = +infinity)

// Saturating unsigned lane add. A carry out means the true sum does not fit,
// so it clamps to all-ones, which doubles as +infinity.
module minplus_lane #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] s
);
  logic [W:0] sum;

  assign sum = {1'b0, a} + {1'b0, b};
  assign s   = sum[W] ? {W{1'b1}} : sum[W-1:0];
endmodule

module minplus_reduce_ctrl #(
  parameter int W     = 16,
  parameter int LANES = 4,
  parameter int LEN_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [LEN_W-1:0]   len,
  input  logic [W-1:0]       c_seed,
  output logic               busy,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [LANES*W-1:0] a_in,
  input  logic [LANES*W-1:0] b_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [W-1:0]       out
);
  localparam int LVLS = (LANES > 1) ? $clog2(LANES) : 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                  state, state_nxt;
  logic [W-1:0]            acc;
  logic [LEN_W-1:0]        cnt;
  logic [LEN_W-1:0]        len_q;

  logic [LANES-1:0][W-1:0] sums;
  logic [LANES-1:0][W-1:0] lvl;
  logic [W-1:0]            beat_min;
  logic                    beat_acc;
  logic                    last_beat;

  // ---------------------------------------------------------------- lanes
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    minplus_lane #(.W(W)) u_lane (
      .a (a_in[i*W +: W]),
      .b (b_in[i*W +: W]),
      .s (sums[i])
    );
  end

  // Balanced pairwise min tree, reduced in place: level l pairs entries
  // 2j/2j+1 into slot j. Strict '<' keeps the even (lower-index) entry on a
  // tie. Reads of 2j, 2j+1 always precede the overwrite of those slots.
  always_comb begin
    lvl = sums;
    for (int l = 0; l < LVLS; l++) begin
      for (int j = 0; j < (LANES >> (l + 1)); j++) begin
        lvl[j] = (lvl[2*j+1] < lvl[2*j]) ? lvl[2*j+1] : lvl[2*j];
      end
    end
    beat_min = lvl[0];
  end

  // ---------------------------------------------------------------- control
  // Handshake outputs decode only the state register, so neither in_valid
  // nor out_ready reaches in_ready/out_valid combinationally.
  assign busy      = (state != IDLE);
  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == DONE);
  assign out       = acc;

  assign beat_acc  = in_valid & in_ready;
  // len_q is never zero in ACCUM, so len_q-1 does not wrap here.
  assign last_beat = (cnt == len_q - 1'b1);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (len != '0) ? ACCUM : DONE;
      ACCUM:   if (beat_acc && last_beat) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------- datapath
  // acc is left alone in IDLE so out keeps the last result after handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      cnt   <= '0;
      len_q <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          acc   <= c_seed;
          cnt   <= '0;
          len_q <= len;
        end
        ACCUM: if (beat_acc) begin
          // '<=' keeps the accumulator on equality.
          acc <= (acc <= beat_min) ? acc : beat_min;
          cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_minplus_reduce_ctrl.sv
// Directed bench for minplus_reduce_ctrl (W=16, LANES=4, LEN_W=8).
// Inputs change 1 time unit after each rising edge; outputs are checked at
// the same point, i.e. they reflect the state after that edge.
module tb_minplus_reduce_ctrl;
  localparam int W = 16, LANES = 4, LEN_W = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [LEN_W-1:0]   len;
  logic [W-1:0]       c_seed;
  logic               busy;
  logic               in_valid;
  logic               in_ready;
  logic [LANES*W-1:0] a_in, b_in;
  logic               out_valid;
  logic               out_ready;
  logic [W-1:0]       out;

  int n_cmp = 0;
  int n_err = 0;

  minplus_reduce_ctrl #(.W(W), .LANES(LANES), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .c_seed    (c_seed),
    .busy      (busy),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input logic [W-1:0] a0, a1, a2, a3,
                          input logic [W-1:0] b0, b1, b2, b3);
    a_in = {a3, a2, a1, a0};
    b_in = {b3, b2, b1, b0};
  endtask

  // One-cycle start pulse; leaves the controller one edge past acceptance.
  task automatic do_start(input logic [LEN_W-1:0] l, input logic [W-1:0] seed);
    start = 1'b1; len = l; c_seed = seed;
    tick();
    start = 1'b0;
  endtask

  // Present one beat for exactly one cycle (caller knows in_ready is high).
  task automatic beat();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Expect a held result, then complete the output handshake.
  task automatic finish_row(input string tag, input logic [W-1:0] exp);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".out"}, 32'(out), 32'(exp));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, ".idle_busy"}, 32'(busy), 32'd0);
    chk({tag, ".idle_ovld"}, 32'(out_valid), 32'd0);
    chk({tag, ".out_hold"}, 32'(out), 32'(exp));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; len = '0; c_seed = '0;
    in_valid = 1'b0; out_ready = 1'b0; a_in = '0; b_in = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.in_ready", 32'(in_ready), 32'd0);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.out", 32'(out), 32'd0);

    // 1: single beat, sums 11,7,53,4 -> 4
    tick();
    chk("t1.pre_ready", 32'(in_ready), 32'd0);
    do_start(8'd1, 16'd100);
    chk("t1.ready", 32'(in_ready), 32'd1);
    chk("t1.busy", 32'(busy), 32'd1);
    set_beat(1, 2, 3, 4, 10, 5, 50, 0);
    beat();
    chk("t1.post_ready", 32'(in_ready), 32'd0);
    finish_row("t1", 16'd4);

    // 2: three beats (mins 20, 9, 15) with two idle cycles between beats
    do_start(8'd3, 16'd100);
    set_beat(20, 30, 40, 50, 0, 0, 0, 0);
    beat();
    tick(); tick();
    chk("t2.gap_ovld", 32'(out_valid), 32'd0);
    chk("t2.gap_ready", 32'(in_ready), 32'd1);
    set_beat(50, 4, 60, 70, 0, 5, 0, 0);
    beat();
    tick(); tick();
    chk("t2.gap2_ovld", 32'(out_valid), 32'd0);
    set_beat(15, 16, 17, 18, 0, 0, 0, 0);
    beat();
    chk("t2.post_ready", 32'(in_ready), 32'd0);
    finish_row("t2", 16'd9);

    // 3: saturation -- every lane clamps to 0xFFFF
    do_start(8'd1, 16'hFFFF);
    set_beat(16'hFFF0, 16'hFFF0, 16'hFFF0, 16'hFFF0,
             16'h0020, 16'h0020, 16'h0020, 16'h0020);
    beat();
    finish_row("t3a", 16'hFFFF);
    do_start(8'd1, 16'd5);
    beat();
    finish_row("t3b", 16'd5);

    // 4: len=0 -> result the cycle after start; a stray beat is not taken
    in_valid = 1'b1;
    set_beat(0, 0, 0, 0, 0, 0, 0, 0);
    do_start(8'd0, 16'd42);
    chk("t4.ready", 32'(in_ready), 32'd0);
    chk("t4.out_valid", 32'(out_valid), 32'd1);
    chk("t4.out", 32'(out), 32'd42);
    in_valid = 1'b0;

    // 5: backpressure in DONE while start is pulsed
    for (int i = 0; i < 5; i++) begin
      start = i[0]; len = 8'd1; c_seed = 16'd7;
      tick();
      chk("t5.hold_out", 32'(out), 32'd42);
      chk("t5.hold_busy", 32'(busy), 32'd1);
      chk("t5.hold_ovld", 32'(out_valid), 32'd1);
    end
    // start held through the handshake cycle must not be taken there
    start = 1'b1; len = 8'd1; c_seed = 16'd77; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t5.rel_busy", 32'(busy), 32'd0);
    chk("t5.rel_ovld", 32'(out_valid), 32'd0);
    tick();
    start = 1'b0;
    chk("t5.new_ready", 32'(in_ready), 32'd1);
    set_beat(30, 31, 32, 33, 0, 0, 0, 0);
    beat();
    finish_row("t5", 16'd30);

    // 6: reset after two low beats of a 4-beat row
    do_start(8'd4, 16'd3);
    set_beat(1, 9, 9, 9, 0, 0, 0, 0);
    beat();
    set_beat(2, 9, 9, 9, 0, 0, 0, 0);
    beat();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6.busy", 32'(busy), 32'd0);
    chk("t6.ready", 32'(in_ready), 32'd0);
    chk("t6.ovld", 32'(out_valid), 32'd0);
    chk("t6.out", 32'(out), 32'd0);
    do_start(8'd1, 16'd100);
    set_beat(50, 60, 70, 80, 0, 0, 0, 0);
    beat();
    finish_row("t6", 16'd50);

    // tie and equality: lanes 1 and 2 both 8, seed also 8
    do_start(8'd1, 16'd8);
    set_beat(9, 8, 8, 12, 0, 0, 0, 0);
    beat();
    finish_row("t7", 16'd8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
